// File: rtl/led_frame_buf.sv
// Double-buffered LED matrix frame store: writes land in the back bank, the scanner reads the front bank.
// A clear engine zeroes the back bank one cell per cycle; bank swaps wait until no clear is running.
module led_frame_buf #(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int DW      = 4,
  parameter int WR_EDGE = 1,
  parameter int RAW     = $clog2(ROWS),
  parameter int CAW     = $clog2(COLS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [DW-1:0]  wr_data,
  input  logic [RAW-1:0] wr_row,
  input  logic [CAW-1:0] wr_col,
  input  logic           wr_en,
  input  logic [RAW-1:0] rd_row,
  input  logic [CAW-1:0] rd_col,
  input  logic           rd_en,
  output logic [DW-1:0]  rd_data,
  output logic           rd_valid,
  input  logic           swap_req,
  input  logic           clr,
  output logic           busy,
  output logic           front_sel
);

  localparam int CELLS = ROWS * COLS;
  localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(CELLS - 1);
  localparam logic [RAW:0]   ROW_LIM  = (RAW + 1)'(ROWS);
  localparam logic [CAW:0]   COL_LIM  = (CAW + 1)'(COLS);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] clr_idx_q, clr_idx_d;
  logic          wr_en_d;
  logic          swap_pending;
  logic          wr_qual, wr_in_range, rd_in_range, wr_go, swap_go;
  logic [IW-1:0] wr_cell, rd_cell;
  logic [DW-1:0] bank [2][CELLS];

  assign wr_qual     = (WR_EDGE != 0) ? (wr_en & ~wr_en_d) : wr_en;
  assign wr_in_range = ({1'b0, wr_row} < ROW_LIM) && ({1'b0, wr_col} < COL_LIM);
  assign rd_in_range = ({1'b0, rd_row} < ROW_LIM) && ({1'b0, rd_col} < COL_LIM);
  assign wr_cell     = IW'(int'(wr_row) * COLS + int'(wr_col));
  assign rd_cell     = IW'(int'(rd_row) * COLS + int'(rd_col));
  // A write that lands together with a clear request would be wiped anyway, so it is dropped outright.
  assign wr_go       = wr_qual && wr_in_range && (state_q == IDLE) && !clr;
  assign busy        = (state_q == CLEAR);
  assign swap_go     = swap_pending && !busy;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      CLEAR: begin
        if (clr_idx_q == LAST_IDX) state_d = IDLE;
        else clr_idx_d = clr_idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Swap requests merge into one pending flag, consumed as soon as no clear is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      clr_idx_q    <= '0;
      wr_en_d      <= 1'b0;
      swap_pending <= 1'b0;
      front_sel    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      wr_en_d   <= wr_en;
      if (swap_go) begin
        front_sel    <= ~front_sel;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_in_range ? bank[front_sel][rd_cell] : '0;
    end
  end

  // Both the clear engine and host writes target the back bank selected before any toggle at this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank <= '{default: '0};
    end else if (busy) begin
      bank[~front_sel][clr_idx_q] <= '0;
    end else if (wr_go) begin
      bank[~front_sel][wr_cell] <= wr_data;
    end
  end

endmodule

// File: doc/led_frame_buf.md
LED_FRAME_BUF -- requirements
Module: led_frame_buf

Interface
- REQ-001: The block SHALL have parameter ROWS, default 8, meaning the number of matrix rows.
- REQ-002: The block SHALL have parameter COLS, default 8, meaning the number of matrix columns.
- REQ-003: The block SHALL have parameter DW, default 4, meaning bits per pixel.
- REQ-004: The block SHALL have parameter WR_EDGE, default 1, meaning 1 = write on wr_en rising edge and 0 = write on every cycle wr_en is high.
- REQ-005: The block SHALL have parameters RAW = clog2(ROWS) and CAW = clog2(COLS), derived, meaning the row and column address widths.
- REQ-006: The block SHALL have port clk, input, 1 bit, meaning the single clock; all logic is on its rising edge.
- REQ-007: The block SHALL have port rst_n, input, 1 bit, meaning reset, which is asynchronous and active-low.
- REQ-008: The block SHALL have port wr_data, input, DW bits, meaning the pixel value to write.
- REQ-009: The block SHALL have ports wr_row and wr_col, input, RAW and CAW bits, meaning the binary write address into the back bank.
- REQ-010: The block SHALL have port wr_en, input, 1 bit, meaning write request, qualified per WR_EDGE.
- REQ-011: The block SHALL have ports rd_row and rd_col, input, RAW and CAW bits, meaning the binary scan-read address into the front bank.
- REQ-012: The block SHALL have port rd_en, input, 1 bit, meaning scan read request.
- REQ-013: The block SHALL have port rd_data, output, DW bits, meaning the registered read data.
- REQ-014: The block SHALL have port rd_valid, output, 1 bit, meaning rd_data is valid this cycle.
- REQ-015: The block SHALL have port swap_req, input, 1 bit, meaning a single-cycle pulse requesting a front/back bank exchange.
- REQ-016: The block SHALL have port clr, input, 1 bit, meaning a single-cycle pulse to clear the back bank.
- REQ-017: The block SHALL have port busy, output, 1 bit, meaning a clear is in progress.
- REQ-018: The block SHALL have port front_sel, output, 1 bit, meaning the index of the bank currently displayed.

Function
- REQ-019: The block SHALL hold two banks, each ROWS x COLS x DW, with front bank = front_sel and back bank = ~front_sel.
- REQ-020: When WR_EDGE=1, a write SHALL occur when wr_en=1 and wr_en was 0 in the previous cycle (registered wr_en_d); when WR_EDGE=0, a write SHALL occur on every cycle wr_en=1.
- REQ-021: A qualified write SHALL update back[wr_row][wr_col] at the clock edge; the write SHALL be dropped if wr_row>=ROWS or wr_col>=COLS.
- REQ-022: Writes SHALL never target the front bank.
- REQ-023: Read latency SHALL be 1 cycle: rd_en=1 in cycle N gives rd_valid=1 and rd_data=front[rd_row][rd_col] in cycle N+1.
- REQ-024: rd_valid SHALL be 0 in any cycle following rd_en=0, and rd_data SHALL hold its last value in that case.
- REQ-025: A read at an out-of-range address SHALL return rd_data=0 with rd_valid=1.
- REQ-026: Reads and writes in the same cycle SHALL be independent, because they target different banks.
- REQ-027: The clear FSM SHALL have two states, IDLE and CLEAR.
- REQ-028: In IDLE, clr=1 SHALL enter CLEAR, set busy=1 and reset an index counter to 0.
- REQ-029: In CLEAR, the FSM SHALL write 0 to one back-bank cell per cycle in row-major order, for ROWS*COLS cycles.
- REQ-030: After the last cell, the FSM SHALL return to IDLE with busy=0 on the following cycle.
- REQ-031: clr asserted while already in CLEAR SHALL be ignored.
- REQ-032: While busy=1, all qualified writes SHALL be dropped; a write coinciding with clr in IDLE SHALL also be dropped.
- REQ-033: On swap_req=1, a swap_pending flag SHALL be set.
- REQ-034: When swap_pending=1 and busy=0, front_sel SHALL toggle at the next edge and swap_pending SHALL clear.
- REQ-035: A swap requested during CLEAR SHALL execute on the first cycle after busy falls.
- REQ-036: Multiple swap_req pulses before execution SHALL cause only one swap.
- REQ-037: A write in the cycle in which front_sel toggles SHALL go to the pre-toggle back bank.
- REQ-038: A read issued in the cycle in which front_sel toggles SHALL use the pre-toggle front bank.

Reset
- REQ-039: On rst_n=0, the block SHALL asynchronously set front_sel=0, rd_data=0, rd_valid=0, busy=0, FSM=IDLE, swap_pending=0 and wr_en_d=0.
- REQ-040: On rst_n=0, the block SHALL set all cells of both banks to 0.
- REQ-041: Reset asserted mid-clear or mid-swap SHALL abort the operation, with no partial state surviving.
- REQ-042: After reset release with WR_EDGE=1 and wr_en held at 1, exactly one write SHALL occur, on the first clock edge.

Verification
- REQ-043: Defaults, WR_EDGE=1: write 4'hA to (3,5) with wr_en held high 4 cycles, swap, then read (3,5) -> rd_valid=1 with 4'hA one cycle later; exactly one write is counted.
- REQ-044: Before the swap, read (3,5) -> 0, since the front bank is untouched; after the swap, front_sel=1.
- REQ-045: Fill the back bank, pulse clr, and write during busy -> busy high exactly 64 cycles, the write is dropped, and after a swap every cell reads 0.
- REQ-046: Pulse swap_req on cycle 10 of a clear -> front_sel toggles on the cycle after busy falls; 3 extra swap_req pulses during the clear still yield a single toggle.
- REQ-047: With ROWS=6, COLS=10, DW=8, WR_EDGE=0: write to (6,0) is dropped, read of (7,2) returns 0 with rd_valid=1, and wr_en held 3 cycles to (1,9) with changing data leaves the last value.
- REQ-048: Assert rst_n=0 at clear index 20 -> all outputs are 0 immediately and both banks read 0 after release.
